// File: rtl/port2axis_rr.sv
// port2axis_rr: per-port word FIFOs feeding a frame-atomic round-robin
// arbiter that drives a single AXI4-Stream master through one output register.
//
// Output handshake: a word is transferred on a rising CLK edge where
// M_AXIS_TVALID=1 and M_AXIS_TREADY=1. While TVALID=1 and TREADY=0, TDATA,
// TLAST and TUSER hold stable. TVALID never depends combinationally on TREADY.
// The input side has no handshake: D_VALID pushes unconditionally, and D_BP
// is only an early warning, so the source must honour it to avoid drops.
module port2axis_rr #(
    parameter int NPORTS   = 4,
    parameter int LANES    = 8,
    parameter int DEPTH    = 16,
    parameter int BP_SLACK = 4
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic [NPORTS-1:0][LANES-1:0][63:0] D,
    input  logic [NPORTS-1:0]                  D_VALID,
    input  logic [NPORTS-1:0]                  D_EOF,
    output logic [NPORTS-1:0]                  D_BP,
    output logic [LANES*64-1:0]                M_AXIS_TDATA,
    output logic [LANES*8-1:0]                 M_AXIS_TKEEP,
    output logic [$clog2(NPORTS)-1:0]          M_AXIS_TUSER,
    output logic                               M_AXIS_TVALID,
    output logic                               M_AXIS_TLAST,
    input  logic                               M_AXIS_TREADY,
    output logic [NPORTS-1:0]                  OVF,
    output logic                               DBG_STATE,
    output logic [$clog2(NPORTS)-1:0]          DBG_PTR
);

    localparam int DW = LANES * 64;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(NPORTS);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] BP_THR   = CW'(DEPTH - BP_SLACK);
    localparam logic [PW-1:0] LAST_PORT = PW'(NPORTS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // FIFO storage: each entry is {eof, data}
    logic [DW:0]                  mem_q [NPORTS][DEPTH];
    logic [NPORTS-1:0][AW-1:0]    wr_ptr_q;
    logic [NPORTS-1:0][AW-1:0]    rd_ptr_q;
    logic [NPORTS-1:0][CW-1:0]    count_q;
    logic [NPORTS-1:0]            ovf_q;
    logic [NPORTS-1:0]            bp_q;

    logic [NPORTS-1:0]            push;
    logic [NPORTS-1:0]            pop;
    logic [NPORTS-1:0]            empty;
    logic [NPORTS-1:0]            head_eof;
    logic [DW-1:0]                head_data [NPORTS];

    // Arbiter state
    arb_state_e                   state_q, state_d;
    logic [PW-1:0]                grant_q, grant_d;
    logic [PW-1:0]                ptr_q, ptr_d;
    logic                         found;
    logic [PW-1:0]                sel;
    logic [PW-1:0]                sel_next;
    logic                         can_load;
    logic                         pop_any;
    logic [PW-1:0]                pop_port;

    // Output register
    logic                         tvalid_q;
    logic                         tlast_q;
    logic [PW-1:0]                tuser_q;
    logic [DW-1:0]                tdata_q;

    // Per-port status: a push is refused only when the FIFO is already full
    // before any same-cycle pop, so a full FIFO drops even while draining.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            empty[p]     = (count_q[p] == '0);
            push[p]      = D_VALID[p] && (count_q[p] != FULL_CNT);
            head_eof[p]  = mem_q[p][rd_ptr_q[p]][DW];
            head_data[p] = mem_q[p][rd_ptr_q[p]][DW-1:0];
        end
    end

    // FIFO pointers, occupancy, sticky overflow and registered backpressure
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            bp_q     <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (push[p]) begin
                    wr_ptr_q[p] <= wr_ptr_q[p] + AW'(1);
                end
                if (pop[p]) begin
                    rd_ptr_q[p] <= rd_ptr_q[p] + AW'(1);
                end
                case ({push[p], pop[p]})
                    2'b10:   count_q[p] <= count_q[p] + CW'(1);
                    2'b01:   count_q[p] <= count_q[p] - CW'(1);
                    default: count_q[p] <= count_q[p];
                endcase
                if (D_VALID[p] && !push[p]) begin
                    ovf_q[p] <= 1'b1;
                end
                bp_q[p] <= (count_q[p] >= BP_THR);
            end
        end
    end

    // FIFO data write; storage needs no reset because occupancy gates reads
    always_ff @(posedge CLK) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (push[p]) begin
                mem_q[p][wr_ptr_q[p]] <= {D_EOF[p], D[p]};
            end
        end
    end

    assign can_load = !tvalid_q || M_AXIS_TREADY;

    // Round-robin search: first non-empty FIFO from ptr_q upward, wrapping
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            int            idx;
            logic [PW-1:0] cand;
            idx = int'(ptr_q) + i;
            if (idx >= NPORTS) begin
                idx = idx - NPORTS;
            end
            cand = PW'(idx);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        sel_next = (sel == LAST_PORT) ? '0 : sel + PW'(1);
    end

    // Arbiter state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Arbiter next state: a grant is held from a frame's first word to its EOF
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (can_load && found) begin
                    grant_d = sel;
                    ptr_d   = sel_next;
                    state_d = head_eof[sel] ? IDLE : BURST;
                end
            end
            BURST: begin
                if (can_load && !empty[grant_q] && head_eof[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter outputs: which FIFO pops this cycle and whose word loads
    always_comb begin
        pop      = '0;
        pop_any  = 1'b0;
        pop_port = grant_q;
        case (state_q)
            IDLE: begin
                if (can_load && found) begin
                    pop[sel] = 1'b1;
                    pop_any  = 1'b1;
                    pop_port = sel;
                end
            end
            BURST: begin
                if (can_load && !empty[grant_q]) begin
                    pop[grant_q] = 1'b1;
                    pop_any      = 1'b1;
                end
            end
            default: pop_any = 1'b0;
        endcase
    end

    // Output register control: load on pop, drain on accept, hold when stalled
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
        end else if (pop_any) begin
            tvalid_q <= 1'b1;
            tlast_q  <= head_eof[pop_port];
            tuser_q  <= pop_port;
        end else if (M_AXIS_TREADY) begin
            tvalid_q <= 1'b0;
        end
    end

    // Output data path; contents are qualified by TVALID so no reset
    always_ff @(posedge CLK) begin
        if (pop_any) begin
            tdata_q <= head_data[pop_port];
        end
    end

    assign D_BP          = bp_q;
    assign OVF           = ovf_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TKEEP  = '1;
    assign M_AXIS_TUSER  = tuser_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign DBG_STATE     = state_q;
    assign DBG_PTR       = ptr_q;

endmodule

// File: tb/tb_port2axis_rr.sv
// Directed bench for port2axis_rr with default parameters
// (4 ports, 8 lanes, depth 16, slack 4).
module tb_port2axis_rr;

    localparam int NP = 4;
    localparam int LN = 8;
    localparam int DW = LN * 64;
    localparam int OW = DW + 4;

    logic                       clk;
    logic                       rst_n;
    logic [NP-1:0][LN-1:0][63:0] d;
    logic [NP-1:0]              d_valid;
    logic [NP-1:0]              d_eof;
    logic [NP-1:0]              d_bp;
    logic [DW-1:0]              tdata;
    logic [LN*8-1:0]            tkeep;
    logic [1:0]                 tuser;
    logic                       tvalid;
    logic                       tlast;
    logic                       tready;
    logic [NP-1:0]              ovf;
    logic                       dbg_state;
    logic [1:0]                 dbg_ptr;

    int checks;
    int passes;
    int fails;
    logic [OW-1:0] exp_q[$];
    int rr_port[6] = '{0, 0, 1, 1, 3, 3};

    port2axis_rr #(
        .NPORTS  (NP),
        .LANES   (LN),
        .DEPTH   (16),
        .BP_SLACK(4)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .D            (d),
        .D_VALID      (d_valid),
        .D_EOF        (d_eof),
        .D_BP         (d_bp),
        .M_AXIS_TDATA (tdata),
        .M_AXIS_TKEEP (tkeep),
        .M_AXIS_TUSER (tuser),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TLAST (tlast),
        .M_AXIS_TREADY(tready),
        .OVF          (ovf),
        .DBG_STATE    (dbg_state),
        .DBG_PTR      (dbg_ptr)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    // Word pattern: every lane distinct, tagged with port and word number
    function automatic logic [DW-1:0] mk(int p, int n);
        logic [DW-1:0] w;
        w = '0;
        for (int l = 0; l < LN; l++) begin
            w[l*64 +: 64] = {8'(l), 8'hA5, 16'(p), 32'(n)};
        end
        return w;
    endfunction

    // Expected valid output beat {tvalid, tlast, tuser, tdata}
    function automatic logic [OW-1:0] ev(bit last, int p, int n);
        return {1'b1, last, 2'(p), mk(p, n)};
    endfunction

    function automatic logic [OW-1:0] out_word();
        return {tvalid, tlast, tuser, tdata};
    endfunction

    task automatic chk(string tag, logic [OW-1:0] obs, logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int p, int n, bit eof);
        d[2'(p)]       = mk(p, n);
        d_valid[2'(p)] = 1'b1;
        d_eof[2'(p)]   = eof;
    endtask

    task automatic idle_in();
        d_valid = '0;
        d_eof   = '0;
    endtask

    initial begin
        int            k;
        int            got;
        int            cyc;
        bit            hold;
        logic [OW-1:0] snap;

        checks = 0;
        passes = 0;
        fails  = 0;
        d      = '0;
        rst_n  = 1'b0;
        tready = 1'b0;
        idle_in();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_tvalid", int'(tvalid), 0);
        chk1("rst_tlast", int'(tlast), 0);
        chk1("rst_tuser", int'(tuser), 0);
        chk1("rst_bp", int'(d_bp), 0);
        chk1("rst_ovf", int'(ovf), 0);
        chk1("rst_state", int'(dbg_state), 0);
        chk1("rst_ptr", int'(dbg_ptr), 0);
        chk("tkeep", OW'(tkeep), OW'({64{1'b1}}));
        rst_n = 1'b1;

        // Round robin: ports 0,1,3 each send a 2-word frame together
        tready = 1'b1;
        drive(0, 0, 0); drive(1, 0, 0); drive(3, 0, 0);
        step();
        chk1("rr_latency", int'(tvalid), 0);
        drive(0, 1, 1); drive(1, 1, 1); drive(3, 1, 1);
        step();
        idle_in();
        for (int i = 0; i < 6; i++) begin
            chk("rr_word", out_word(), ev(i % 2 == 1, rr_port[i], i % 2));
            step();
        end
        chk1("rr_end_tvalid", int'(tvalid), 0);
        chk1("rr_end_ptr", int'(dbg_ptr), 0);
        chk1("rr_end_state", int'(dbg_state), 0);

        // Single 3-word frame on port 2
        drive(2, 0, 0);
        step();
        chk1("sf_latency", int'(tvalid), 0);
        drive(2, 1, 0);
        step();
        chk("sf_w0", out_word(), ev(0, 2, 0));
        drive(2, 2, 1);
        step();
        chk("sf_w1", out_word(), ev(0, 2, 1));
        idle_in();
        step();
        chk("sf_w2", out_word(), ev(1, 2, 2));
        step();
        chk1("sf_end_tvalid", int'(tvalid), 0);
        chk1("sf_end_ptr", int'(dbg_ptr), 3);

        // Backpressure and overflow: hold a port 1 word in the output register
        tready = 1'b0;
        drive(1, 0, 1);
        step();
        idle_in();
        step();
        chk("bp_preload", out_word(), ev(1, 1, 0));
        for (k = 0; k < 17; k++) begin
            drive(0, k, k == 15);
            step();
            if (k == 11) chk1("bp_low_after_12th", int'(d_bp[0]), 0);
            if (k == 12) chk1("bp_high_next_cycle", int'(d_bp[0]), 1);
            if (k == 15) chk1("ovf_clear_at_full", int'(ovf[0]), 0);
            if (k == 16) chk1("ovf_set_on_drop", int'(ovf), 1);
        end
        idle_in();
        tready = 1'b1;
        for (k = 0; k < 16; k++) begin
            step();
            chk("bp_drain", out_word(), ev(k == 15, 0, k));
        end
        step();
        chk1("bp_drop_absent", int'(tvalid), 0);
        chk1("bp_released", int'(d_bp[0]), 0);
        chk1("ovf_sticky", int'(ovf[0]), 1);

        // Stall: TREADY toggles during a 5-word port 3 frame
        for (int i = 0; i < 5; i++) exp_q.push_back(ev(i == 4, 3, i));
        k   = 0;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 40) begin
            if (k < 5) begin
                drive(3, k, k == 4);
                k++;
            end else begin
                idle_in();
            end
            tready = (cyc % 2 == 0);
            hold   = tvalid && !tready;
            snap   = out_word();
            if (tvalid && tready) begin
                chk("stall_xfer", out_word(), exp_q.pop_front());
                got++;
            end
            step();
            if (hold) chk("stall_hold", out_word(), snap);
            cyc++;
        end
        chk1("stall_count", got, 5);
        idle_in();
        tready = 1'b1;
        step();
        step();
        chk1("stall_no_dup", int'(tvalid), 0);

        // Mid-frame gap on port 1 while port 0 waits
        drive(1, 0, 0);
        step();
        drive(1, 1, 0);
        drive(0, 0, 1);
        step();
        idle_in();
        chk("gap_w0", out_word(), ev(0, 1, 0));
        step();
        chk("gap_w1", out_word(), ev(0, 1, 1));
        step();
        chk1("gap_hold1", int'(tvalid), 0);
        step();
        chk1("gap_hold2", int'(tvalid), 0);
        drive(1, 2, 0);
        step();
        idle_in();
        chk1("gap_hold3", int'(tvalid), 0);
        drive(1, 3, 1);
        step();
        idle_in();
        chk("gap_w2", out_word(), ev(0, 1, 2));
        step();
        chk("gap_w3", out_word(), ev(1, 1, 3));
        step();
        chk("gap_port0", out_word(), ev(1, 0, 0));
        step();
        chk1("gap_end", int'(tvalid), 0);

        // Reset mid-frame on a 4-word port 2 frame
        drive(2, 0, 0);
        step();
        drive(2, 1, 0);
        step();
        chk("mr_w0", out_word(), ev(0, 2, 0));
        drive(2, 2, 0);
        step();
        chk("mr_w1", out_word(), ev(0, 2, 1));
        rst_n = 1'b0;
        idle_in();
        #1;
        chk1("mr_tvalid", int'(tvalid), 0);
        chk1("mr_tlast", int'(tlast), 0);
        chk1("mr_tuser", int'(tuser), 0);
        chk1("mr_ovf", int'(ovf), 0);
        chk1("mr_bp", int'(d_bp), 0);
        step();
        step();
        rst_n = 1'b1;
        drive(3, 10, 0);
        step();
        chk1("mr_new_latency", int'(tvalid), 0);
        drive(3, 11, 1);
        step();
        idle_in();
        chk("mr_new_w0", out_word(), ev(0, 3, 10));
        step();
        chk("mr_new_w1", out_word(), ev(1, 3, 11));
        step();
        chk1("mr_no_stale", int'(tvalid), 0);
        chk1("mr_state", int'(dbg_state), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/port2axis_rr.md
PORT2AXIS_RR -- requirements
Module: port2axis_rr

Interface
REQ-001 The block SHALL have parameter NPORTS, default 4: number of input ports, 2..8.
REQ-002 The block SHALL have parameter LANES, default 8: 64-bit lanes per word; TDATA width = LANES*64.
REQ-003 The block SHALL have parameter DEPTH, default 16: per-port FIFO entries, power of 2, at least 8.
REQ-004 The block SHALL have parameter BP_SLACK, default 4: free entries remaining when D_BP asserts.
REQ-005 The block SHALL have port CLK, input, 1: single clock for all logic.
REQ-006 The block SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-007 The block SHALL have port D, input, [NPORTS-1:0][LANES-1:0][63:0]: per-port data word.
REQ-008 The block SHALL have port D_VALID, input, NPORTS: per-port word strobe.
REQ-009 The block SHALL have port D_EOF, input, NPORTS: the word is the last word of its frame.
REQ-010 The block SHALL have port D_BP, output, NPORTS: per-port backpressure to the source.
REQ-011 The block SHALL have port M_AXIS_TDATA, output, LANES*64: output data.
REQ-012 The block SHALL have port M_AXIS_TKEEP, output, LANES*8: byte enables.
REQ-013 The block SHALL have port M_AXIS_TUSER, output, clog2(NPORTS): source port index.
REQ-014 The block SHALL have port M_AXIS_TVALID, output, 1: output word valid.
REQ-015 The block SHALL have port M_AXIS_TLAST, output, 1: output word is last of frame.
REQ-016 The block SHALL have port M_AXIS_TREADY, input, 1: downstream ready.
REQ-017 The block SHALL have port OVF, output, NPORTS: sticky per-port overflow flag.

Function
REQ-018 The block SHALL give each port a FIFO of DEPTH entries, each entry holding {D, D_EOF}.
- Push: every cycle D_VALID[p]=1, with no dependence on D_BP.
REQ-019 If FIFO p holds DEPTH entries (count before any same-cycle pop) when D_VALID[p]=1, the block SHALL drop the word and set OVF[p]=1; OVF[p] stays set until reset.
REQ-020 D_BP[p] SHALL be registered and equal 1 exactly when FIFO p count >= DEPTH-BP_SLACK; it updates one cycle after the count changes.
REQ-021 The arbiter SHALL have two states, IDLE and BURST, plus registers GRANT (port index) and PTR (round-robin pointer).
REQ-022 In IDLE, when the output register can load, the arbiter SHALL select the first non-empty FIFO searching from PTR upward modulo NPORTS, pop it in the same cycle, and latch GRANT.
- The output register can load when it is empty or M_AXIS_TREADY=1.
REQ-023 On that IDLE pop, the next state SHALL be BURST if the popped EOF=0 and IDLE if EOF=1; in both cases PTR <= GRANT+1 modulo NPORTS.
REQ-024 In BURST, the arbiter SHALL pop only FIFO GRANT, whenever that FIFO is non-empty and the output register can load; other ports are never served mid-frame.
REQ-025 In BURST, popping a word with EOF=1 SHALL return the arbiter to IDLE at that edge.
- The next frame may pop the following cycle, so there is no output bubble between frames.
REQ-026 In BURST, an empty FIFO GRANT SHALL stall the output (TVALID falls once the register drains) without releasing the grant.
REQ-027 A pop SHALL load the output register with TDATA = word, TLAST = EOF, TUSER = GRANT, TVALID = 1.
REQ-028 With no pop and M_AXIS_TREADY=1, the block SHALL clear TVALID; with M_AXIS_TREADY=0, the register SHALL hold all outputs stable.
REQ-029 Latency: a word pushed at edge t into an empty FIFO, with the arbiter in IDLE and the output register loadable, SHALL appear with TVALID=1 after edge t+1 (2 cycles).
REQ-030 Sustained throughput SHALL be one word per cycle while TREADY=1 and the selected FIFO is non-empty.
REQ-031 M_AXIS_TKEEP SHALL be constant all-ones.
REQ-032 Simultaneous push and pop on one FIFO SHALL leave its count unchanged, except for the full-drop case in REQ-019.

Reset
REQ-033 RST_N=0 SHALL asynchronously clear:
- all FIFO counts and pointers, OVF, D_BP, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER
- state to IDLE, PTR and GRANT to 0
REQ-034 TDATA contents need not reset.
REQ-035 Reset mid-frame SHALL discard all buffered words with no TLAST emitted for the truncated frame.
REQ-036 After RST_N deasserts, the first push SHALL be accepted at the first rising CLK edge.

Verification
REQ-037 Single frame: port 2 sends 3 words (EOF on the third), TREADY=1 -> TVALID 2 cycles after the first D_VALID, 3 consecutive words, TUSER=2, TLAST on the third only.
REQ-038 Round robin: ports 0, 1 and 3 each send a 2-word frame on the same cycle, PTR=0 -> frame order 0,1,3 with no interleaving; 6 contiguous TVALID cycles; PTR=0 afterwards.
REQ-039 Backpressure: DEPTH=16, BP_SLACK=4, TREADY=0, port 0 streams 12 words -> D_BP[0] rises the cycle after the 12th push; after 16 pushes, a 17th word is dropped and OVF[0]=1.
REQ-040 Stall: TREADY toggles 1/0 every cycle during a 5-word frame -> TDATA/TLAST/TUSER stable while TREADY=0; all 5 words delivered in order with none lost or duplicated.
REQ-041 Mid-frame gap: port 1 frame stalls 3 cycles after word 2 while port 0 has data -> no port 0 word appears until port 1's EOF word has been transferred.
REQ-042 Reset mid-frame: RST_N=0 after 2 of 4 words -> TVALID=0 immediately; after release a new port 3 frame emerges first with TUSER=3 and no stale data.
